// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and slice-count helper for the registered CLA adder
package adder_pkg;

    localparam int DEFAULT_N = 10;
    localparam int CLA_W     = 4;

    function automatic int num_slices(input int n);
        return (n + CLA_W - 1) / CLA_W;
    endfunction

endpackage

// File: rtl/adder_cla_slice.sv
// rtl/adder_cla_slice.sv - W-bit carry-lookahead slice with group generate/propagate carry-out
module adder_cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         grp_g;
    logic         grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // Group G/P let the slice carry-out skip over the internal bit carries.
    always_comb begin
        c     = '0;
        c[0]  = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            grp_g  = g[i] | (p[i] & grp_g);
            grp_p  = grp_p & p[i];
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = grp_g | (grp_p & cin);

endmodule

// File: rtl/adder.sv
// rtl/adder.sv - registered N-bit unsigned adder built from a chain of CLA slices
module adder
    import adder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NS = num_slices(N);

    logic [NS:0]  carry;
    logic [N-1:0] sum_d;
    logic         cout_d;
    logic [N-1:0] sum_q;
    logic         cout_q;

    assign carry[0] = 1'b0;

    // The final slice is narrower when N is not a multiple of CLA_W.
    for (genvar k = 0; k < NS; k++) begin : g_slice
        localparam int LO = k * CLA_W;
        localparam int SW = (k == NS - 1) ? (N - LO) : CLA_W;

        adder_cla_slice #(.W(SW)) u_slice (
            .a    (input1[LO +: SW]),
            .b    (input2[LO +: SW]),
            .cin  (carry[k]),
            .s    (sum_d[LO +: SW]),
            .cout (carry[k+1])
        );
    end

    assign cout_d = carry[NS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - directed and randomized checks of the registered adder at N=10, 7 and 13
module tb_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  input1 = '0;
    logic [9:0]  input2 = '0;
    logic [9:0]  sum;
    logic        cout;

    logic [6:0]  a7 = '0, b7 = '0, s7;
    logic        c7;
    logic [12:0] a13 = '0, b13 = '0, s13;
    logic        c13;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder #(.N(10)) dut (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2), .sum(sum), .cout(cout)
    );
    adder #(.N(7)) dut7 (
        .clk(clk), .rst(rst), .input1(a7), .input2(b7), .sum(s7), .cout(c7)
    );
    adder #(.N(13)) dut13 (
        .clk(clk), .rst(rst), .input1(a13), .input2(b13), .sum(s13), .cout(c13)
    );

    task automatic test_reset();
        #1 rst = 1'b1;
        input1 = 10'h3FF;
        input2 = 10'h3FF;
        #1;
        total++;
        if ({cout, sum} !== 11'h000)
            $display("FAIL reset_no_clock: cout=%0b sum=%03h expected cout=0 sum=000", cout, sum);
        else passed++;
        total++;
        if ({c7, s7} !== 8'h00 || {c13, s13} !== 14'h0000)
            $display("FAIL reset_widths: s7=%h c7=%b s13=%h c13=%b expected all zero", s7, c7, s13, c13);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flits();
        logic [19:0] flits  [8] = '{20'hFFFF0, 20'h000FF, 20'hFF000, 20'h0FFFF,
                                    20'hFFFFF, 20'h00000, 20'hAA955, 20'h00401};
        logic [10:0] expect_v [8] = '{11'h7EF, 11'h0FF, 11'h3FC, 11'h43E,
                                      11'h7FE, 11'h000, 11'h3FF, 11'h002};
        logic [10:0] prev;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            prev   = {cout, sum};
            input1 = flits[i][9:0];
            input2 = flits[i][19:10];
            #1;
            if (i > 0) begin
                total++;
                if ({cout, sum} !== prev)
                    $display("FAIL no_comb_path[%0d]: {cout,sum}=%03h expected %03h", i, {cout, sum}, prev);
                else passed++;
            end
            @(posedge clk);
            #1;
            total++;
            if ({cout, sum} !== expect_v[i])
                $display("FAIL flit[%0d] %05h: cout=%0b sum=%03h expected cout=%0b sum=%03h",
                         i, flits[i], cout, sum, expect_v[i][10], expect_v[i][9:0]);
            else passed++;
        end
    endtask

    task automatic test_ripple_and_async_reset();
        @(negedge clk);
        input1 = 10'h3FF;
        input2 = 10'h001;
        @(posedge clk);
        #1;
        total++;
        if ({cout, sum} !== 11'h400)
            $display("FAIL full_ripple: cout=%0b sum=%03h expected cout=1 sum=000", cout, sum);
        else passed++;
        @(negedge clk);
        input1 = 10'h155;
        input2 = 10'h0AA;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cout, sum} !== 11'h000)
            $display("FAIL midcycle_reset: cout=%0b sum=%03h expected cout=0 sum=000", cout, sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({cout, sum} !== 11'h000)
            $display("FAIL reset_release_hold: cout=%0b sum=%03h expected cout=0 sum=000", cout, sum);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({cout, sum} !== 11'h1FF)
            $display("FAIL resume_after_reset: cout=%0b sum=%03h expected cout=0 sum=1FF", cout, sum);
        else passed++;
    endtask

    task automatic test_hold_constant();
        int toggles = 0;
        logic [10:0] first;
        @(negedge clk);
        input1 = 10'h2C7;
        input2 = 10'h1B3;
        @(posedge clk);
        #1 first = {cout, sum};
        total++;
        if (first !== 11'h47A)
            $display("FAIL hold_value: {cout,sum}=%03h expected 47A", first);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if ({cout, sum} !== first) toggles++;
        end
        total++;
        if (toggles !== 0)
            $display("FAIL hold_no_toggle: toggles=%0d expected 0", toggles);
        else passed++;
    endtask

    task automatic test_random_widths();
        logic [7:0]  exp7;
        logic [13:0] exp13;
        int bad7 = 0;
        int bad13 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a7   = 7'($urandom);
            b7   = (i == 0) ? 7'h7F : 7'($urandom);
            a13  = 13'($urandom);
            b13  = (i == 0) ? 13'h1FFF : 13'($urandom);
            if (i == 0) a7 = 7'h7F;
            if (i == 0) a13 = 13'h1FFF;
            exp7  = {1'b0, a7} + {1'b0, b7};
            exp13 = {1'b0, a13} + {1'b0, b13};
            @(posedge clk);
            #1;
            if ({c7, s7} !== exp7) begin
                bad7++;
                if (bad7 < 4)
                    $display("FAIL rand_n7[%0d]: {cout,sum}=%02h expected %02h", i, {c7, s7}, exp7);
            end
            if ({c13, s13} !== exp13) begin
                bad13++;
                if (bad13 < 4)
                    $display("FAIL rand_n13[%0d]: {cout,sum}=%04h expected %04h", i, {c13, s13}, exp13);
            end
        end
        total++;
        if (bad7 != 0) $display("FAIL rand_n7_total: errors=%0d expected 0", bad7);
        else passed++;
        total++;
        if (bad13 != 0) $display("FAIL rand_n13_total: errors=%0d expected 0", bad13);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_flits();
        test_ripple_and_async_reset();
        test_hold_constant();
        test_random_widths();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
